// File: rtl/mux1hot_arb_pkg.sv
// rtl/mux1hot_arb_pkg.sv - shared types and constants for the mux1hot round-robin arbiter
// Contents:
//   arb_state_t  arbiter state encoding (idle, owned, turnaround gap)
//   TA_W         width of the turnaround counter
package mux1hot_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWNED = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_t;

   localparam int TA_W = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular first-set search starting at a pointer
// Ports:
//   req    in   N           request vector
//   ptr    in   $clog2(N)   search start position (0..N-1)
//   pick   out  N           one-hot of the chosen requester (zero when none)
//   index  out  $clog2(N)   binary index of the chosen requester (0 when none)
//   any    out  1           at least one request is set
module rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         pick,
   output logic [$clog2(N)-1:0] index,
   output logic                 any
);

   localparam int PW = $clog2(N);

   // ptr + k with an explicit wrap; one extra bit holds the carry before the wrap.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW:0] a);
      if (a >= (PW+1)'(N)) begin
         return PW'(a - (PW+1)'(N));
      end
      return PW'(a);
   endfunction

   always_comb begin
      pick  = '0;
      index = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[wrap_idx({1'b0, ptr} + (PW+1)'(k))]) begin
            any   = 1'b1;
            index = wrap_idx({1'b0, ptr} + (PW+1)'(k));
            pick[wrap_idx({1'b0, ptr} + (PW+1)'(k))] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux1hot_rr_arbiter.sv
// rtl/mux1hot_rr_arbiter.sv - round-robin arbiter driving a registered one-hot mux select
// Optional feature macro: MUX1HOT_ARB_HOLD_LIMIT_EN (forced release after MAX_HOLD owned cycles
// while another requester waits).
// Ports:
//   clk        in   1           clock, all logic on posedge
//   reset_n    in   1           synchronous reset, active-low
//   req        in   N           level requests
//   sel        out  N           registered zero/one-hot mux select
//   sel_valid  out  1           registered, high iff sel != 0
//   owner      out  $clog2(N)   registered binary index of sel, 0 when sel == 0
//   gnt_pulse  out  1           registered, one cycle on each new grant
module mux1hot_rr_arbiter
   import mux1hot_arb_pkg::*;
#(
   parameter int N          = 3,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         sel,
   output logic                 sel_valid,
   output logic [$clog2(N)-1:0] owner,
   output logic                 gnt_pulse
);

   localparam int PW = $clog2(N);

   if (N < 2 || TURNAROUND < 0 || TURNAROUND > 15 || MAX_HOLD < 1) begin : g_param_check
      $error("mux1hot_rr_arbiter: illegal parameter value");
   end

   arb_state_t      state, state_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [TA_W-1:0] ta_cnt, ta_n;
   logic [N-1:0]    sel_n;
   logic [PW-1:0]   owner_n;
   logic            gnt_n;

   logic [N-1:0]    pick;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            take;
   logic            hold_expire;

   rr_pick #(.N(N)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .pick  (pick),
      .index (pick_idx),
      .any   (pick_any)
   );

`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt, hold_n;
   assign hold_expire = (hold_cnt == HW'(MAX_HOLD - 1)) && ((req & ~sel) != '0);
`else
   assign hold_expire = 1'b0;
`endif

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      ta_n    = ta_cnt;
      sel_n   = sel;
      owner_n = owner;
      gnt_n   = 1'b0;
      take    = 1'b0;
`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
      hold_n  = hold_cnt;
`endif
      case (state)
         ARB_IDLE: begin
            take = pick_any;
         end
         ARB_OWNED: begin
            if (req[owner] && !hold_expire) begin
`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
               if (hold_cnt != HW'(MAX_HOLD)) begin
                  hold_n = hold_cnt + 1'b1;
               end
`endif
            end else if (TURNAROUND > 0) begin
               sel_n   = '0;
               owner_n = '0;
               ta_n    = TA_W'(TURNAROUND - 1);
               state_n = ARB_GAP;
            end else if (pick_any && !gnt_pulse) begin
               // Direct handover. ptr already points past the owner, so the owner's
               // own re-request is searched last.
               take = 1'b1;
            end else begin
               // Also taken when the owner dropped in its grant cycle: one zero cycle
               // keeps gnt_pulse from firing on two consecutive cycles.
               sel_n   = '0;
               owner_n = '0;
               state_n = ARB_IDLE;
            end
         end
         ARB_GAP: begin
            if (ta_cnt == '0) begin
               state_n = ARB_IDLE;
            end else begin
               ta_n = ta_cnt - 1'b1;
            end
         end
         default: begin
            sel_n   = '0;
            owner_n = '0;
            state_n = ARB_IDLE;
         end
      endcase

      if (take) begin
         sel_n   = pick;
         owner_n = pick_idx;
         gnt_n   = 1'b1;
         ptr_n   = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
         state_n = ARB_OWNED;
`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
         hold_n  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         ta_cnt    <= '0;
         sel       <= '0;
         sel_valid <= 1'b0;
         owner     <= '0;
         gnt_pulse <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         ta_cnt    <= ta_n;
         sel       <= sel_n;
         sel_valid <= (sel_n != '0);
         owner     <= owner_n;
         gnt_pulse <= gnt_n;
      end
   end

`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_n;
      end
   end
`endif

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// tb/tb_mux1hot_rr_arbiter.sv - directed bench for mux1hot_rr_arbiter (TURNAROUND=1 and TURNAROUND=0 instances)
module tb_mux1hot_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] req;
   logic [2:0] req0;

   logic [2:0] sel, sel0;
   logic       sel_valid, sel_valid0;
   logic [1:0] owner, owner0;
   logic       gnt_pulse, gnt_pulse0;
   logic [1:0] mux_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux1hot_rr_arbiter #(.N(3), .TURNAROUND(1), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .sel       (sel),
      .sel_valid (sel_valid),
      .owner     (owner),
      .gnt_pulse (gnt_pulse)
   );

   mux1hot_rr_arbiter #(.N(3), .TURNAROUND(0), .MAX_HOLD(4)) dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req0),
      .sel       (sel0),
      .sel_valid (sel_valid0),
      .owner     (owner0),
      .gnt_pulse (gnt_pulse0)
   );

   // Mux1hot3 with in0=0, in1=1, in2=2
   assign mux_out = ({2{sel[0]}} & 2'd0) | ({2{sel[1]}} & 2'd1) | ({2{sel[2]}} & 2'd2);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req     = 3'b000;
      req0    = 3'b000;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req     = 3'b111;
      req0    = 3'b000;
      tick();
      tick();
      total++; if (sel !== 3'b000) begin bad++; $display("FAIL reset_sel got=%b want=000", sel); end
      total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL reset_sel_valid got=%b want=0", sel_valid); end
      total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
      total++; if (gnt_pulse !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt_pulse); end
      reset_n = 1'b1;
      tick();
      total++; if (sel !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b want=001", sel); end
      total++; if (gnt_pulse !== 1'b1) begin bad++; $display("FAIL reset_first_gnt got=%b want=1", gnt_pulse); end
      total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL reset_first_valid got=%b want=1", sel_valid); end
      total++; if (mux_out !== 2'd0) begin bad++; $display("FAIL reset_mux_out got=%0d want=0", mux_out); end
   endtask

   task automatic test_rotation();
      logic [2:0] order [4];
      int zeros;
      order = '{3'b001, 3'b010, 3'b100, 3'b001};
      apply_reset();
      req = 3'b111;
      tick();
      total++; if (sel !== order[0]) begin bad++; $display("FAIL rot_first got=%b want=%b", sel, order[0]); end
      for (int i = 1; i < 4; i++) begin
         tick();
         total++; if (sel !== order[i-1] || gnt_pulse !== 1'b0) begin
            bad++; $display("FAIL rot_hold%0d got=%b/%b want=%b/0", i, sel, gnt_pulse, order[i-1]);
         end
         req = 3'b111 & ~order[i-1];
         tick();
         zeros = (sel == 3'b000) ? 1 : 0;
         req = 3'b111;
         tick();
         zeros += (sel == 3'b000) ? 1 : 0;
         tick();
         total++; if (sel !== order[i] || gnt_pulse !== 1'b1) begin
            bad++; $display("FAIL rot_grant%0d got=%b/%b want=%b/1", i, sel, gnt_pulse, order[i]);
         end
         total++; if (owner !== 2'(i % 3)) begin
            bad++; $display("FAIL rot_owner%0d got=%0d want=%0d", i, owner, i % 3);
         end
         total++; if (zeros !== 2) begin
            bad++; $display("FAIL rot_gap%0d got=%0d want=2", i, zeros);
         end
      end
   endtask

   task automatic test_single_requester();
      int pulses;
      apply_reset();
      req = 3'b010;
      tick();
      pulses = gnt_pulse ? 1 : 0;
      total++; if (sel !== 3'b010) begin bad++; $display("FAIL single_grant got=%b want=010", sel); end
      for (int c = 0; c < 20; c++) begin
         tick();
         pulses += gnt_pulse ? 1 : 0;
         total++; if (sel !== 3'b010 || owner !== 2'd1) begin
            bad++; $display("FAIL single_hold%0d got=%b/%0d want=010/1", c, sel, owner);
         end
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", pulses); end
   endtask

   task automatic test_hold_limit();
      apply_reset();
      req = 3'b001;
      tick();
      total++; if (sel !== 3'b001) begin bad++; $display("FAIL hold_grant got=%b want=001", sel); end
      req = 3'b101;
`ifdef MUX1HOT_ARB_HOLD_LIMIT_EN
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (sel !== 3'b001) begin bad++; $display("FAIL hold_owned%0d got=%b want=001", c, sel); end
      end
      tick();
      total++; if (sel !== 3'b000) begin bad++; $display("FAIL hold_gap0 got=%b want=000", sel); end
      tick();
      total++; if (sel !== 3'b000) begin bad++; $display("FAIL hold_gap1 got=%b want=000", sel); end
      tick();
      total++; if (sel !== 3'b100 || gnt_pulse !== 1'b1) begin
         bad++; $display("FAIL hold_next got=%b/%b want=100/1", sel, gnt_pulse);
      end
`else
      for (int c = 0; c < 15; c++) begin
         tick();
         total++; if (sel !== 3'b001) begin bad++; $display("FAIL hold_forever%0d got=%b want=001", c, sel); end
      end
`endif
   endtask

   task automatic test_mid_grant_reset();
      apply_reset();
      req = 3'b100;
      tick();
      total++; if (sel !== 3'b100) begin bad++; $display("FAIL midrst_pre got=%b want=100", sel); end
      req     = 3'b111;
      reset_n = 1'b0;
      tick();
      total++; if (sel !== 3'b000 || sel_valid !== 1'b0 || owner !== 2'd0 || gnt_pulse !== 1'b0) begin
         bad++; $display("FAIL midrst_clear got=%b/%b/%0d/%b want=000/0/0/0", sel, sel_valid, owner, gnt_pulse);
      end
      reset_n = 1'b1;
      tick();
      total++; if (sel !== 3'b001) begin bad++; $display("FAIL midrst_regrant got=%b want=001", sel); end
   endtask

   task automatic test_turnaround0();
      apply_reset();
      req0 = 3'b001;
      tick();
      total++; if (sel0 !== 3'b001 || gnt_pulse0 !== 1'b1) begin
         bad++; $display("FAIL ta0_grant got=%b/%b want=001/1", sel0, gnt_pulse0);
      end
      req0 = 3'b011;
      tick();
      total++; if (sel0 !== 3'b001 || gnt_pulse0 !== 1'b0) begin
         bad++; $display("FAIL ta0_hold got=%b/%b want=001/0", sel0, gnt_pulse0);
      end
      req0 = 3'b010;
      tick();
      total++; if (sel0 !== 3'b010 || gnt_pulse0 !== 1'b1 || owner0 !== 2'd1 || sel_valid0 !== 1'b1) begin
         bad++; $display("FAIL ta0_handover got=%b/%b/%0d/%b want=010/1/1/1", sel0, gnt_pulse0, owner0, sel_valid0);
      end
      req0 = 3'b000;
      tick();
      total++; if (sel0 !== 3'b000 || sel_valid0 !== 1'b0) begin
         bad++; $display("FAIL ta0_idle got=%b/%b want=000/0", sel0, sel_valid0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req     = 3'b000;
      req0    = 3'b000;
      test_reset();
      test_rotation();
      test_single_requester();
      test_hold_limit();
      test_mid_grant_reset();
      test_turnaround0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
